// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with a 2-cycle pixel fetch/output pipeline.
// Define VGA_TEST_PATTERN_EN to fill underflowed pixels with 8 vertical colour bars instead of black.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    output logic        o_pix_req,
    output logic [9:0]  o_pix_x,
    output logic [9:0]  o_pix_y,
    input  logic        i_pix_valid,
    input  logic [23:0] i_pix_rgb,
    output logic        o_frame_start,
    output logic        o_data_en,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_busy,
    output logic        o_underflow,
    input  logic        i_underflow_clr
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [9:0]  h_cnt, v_cnt;
    logic        h_end, v_end, hs_on, vs_on;
    logic        d1_de, d1_hs, d1_vs;
    logic [23:0] fill;

    assign h_end         = h_cnt == H_LAST;
    assign v_end         = v_cnt == V_LAST;
    assign hs_on         = h_cnt >= HS0 && h_cnt < HS1;
    assign vs_on         = v_cnt >= VS0 && v_cnt < VS1;
    assign o_busy        = state != IDLE;
    assign o_pix_req     = o_busy && h_cnt < HA && v_cnt < VA;
    assign o_pix_x       = h_cnt;
    assign o_pix_y       = v_cnt;
    assign o_frame_start = o_busy && h_cnt == '0 && v_cnt == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_enable ? RUN : IDLE;
            RUN:     state_nx = i_enable ? RUN : DRAIN;
            DRAIN:   state_nx = i_enable ? RUN : (h_end && v_end) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_nx;
    end

    // Counters sit at (0,0) while idle so the first RUN cycle is position (0,0).
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 10'd1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 10'd1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] d1_x;
    logic [2:0] bar;
    always_ff @(posedge clock) begin
        d1_x <= reset ? '0 : h_cnt;
    end
    assign bar  = 3'(d1_x / 10'(H_ACTIVE / 8));
    assign fill = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
    assign fill = '0;
`endif

    // Stage 1 tracks the request; stage 2 merges the returned pixel (or fill) with timing.
    always_ff @(posedge clock) begin
        if (reset) begin
            d1_de       <= 1'b0;
            d1_hs       <= 1'b0;
            d1_vs       <= 1'b0;
            o_data_en   <= 1'b0;
            o_hsync     <= ~SYNC_POL;
            o_vsync     <= ~SYNC_POL;
            o_r         <= '0;
            o_g         <= '0;
            o_b         <= '0;
            o_underflow <= 1'b0;
        end else begin
            d1_de           <= o_pix_req;
            d1_hs           <= hs_on;
            d1_vs           <= vs_on;
            o_data_en       <= d1_de;
            o_hsync         <= d1_hs ? SYNC_POL : ~SYNC_POL;
            o_vsync         <= d1_vs ? SYNC_POL : ~SYNC_POL;
            {o_r, o_g, o_b} <= !d1_de ? 24'h0 : i_pix_valid ? i_pix_rgb : fill;
            o_underflow     <= (d1_de && !i_pix_valid) || (o_underflow && !i_underflow_clr);
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: reduced-raster bench; hand-written vector table, directed frame/drain runs,
// then random stimulus against a linear-position reference model.
module tb_vga_timing_ctrl;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit BARS = 1'b1;
`else
    localparam bit BARS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, valid, clr;
    logic [23:0] rgb;
    logic        pix_req, frame_start, data_en, hsync, vsync, busy, underflow;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  r, g, b;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .clock(clk), .reset(rst), .i_enable(en),
        .o_pix_req(pix_req), .o_pix_x(pix_x), .o_pix_y(pix_y),
        .i_pix_valid(valid), .i_pix_rgb(rgb),
        .o_frame_start(frame_start), .o_data_en(data_en),
        .o_hsync(hsync), .o_vsync(vsync),
        .o_r(r), .o_g(g), .o_b(b),
        .o_busy(busy), .o_underflow(underflow), .i_underflow_clr(clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] fill(input int x);
        logic [2:0] k;
        k = BARS ? 3'(x / (HA / 8)) : 3'b000;
        return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // Reference model: a frame-linear position plus a busy flag; pipeline via two history slots.
    typedef struct {
        bit          req;
        int          x;
        bit          hs;
        bit          vs;
        bit          valid;
        logic [23:0] rgb;
    } hist_t;

    hist_t p1, p2;
    bit    m_busy = 0, m_enp = 0, m_uf = 0, armed = 0;
    int    m_pos = 0;

    task automatic cycle(input bit ri, input bit ei, input bit vi, input logic [23:0] ci, input bit ki);
        int    h, v;
        bit    req;
        hist_t cur;
        h   = m_pos % HT;
        v   = m_pos / HT;
        req = m_busy && h < HA && v < VA;
        if (armed) begin
            chk("pix_req", pix_req, req);
            chk("pix_x", pix_x, h);
            chk("pix_y", pix_y, v);
            chk("frame_start", frame_start, m_busy && m_pos == 0);
            chk("busy", busy, m_busy);
            chk("data_en", data_en, p2.req);
            chk("hsync", hsync, p2.hs ? POL : !POL);
            chk("vsync", vsync, p2.vs ? POL : !POL);
            chk("rgb", {r, g, b}, p2.req ? (p1.valid ? p1.rgb : fill(p2.x)) : 24'h0);
            chk("underflow", underflow, m_uf);
        end
        rst = ri; en = ei; valid = vi; rgb = ci; clr = ki;
        cur.req   = req;
        cur.x     = h;
        cur.hs    = h >= HA + HF && h < HA + HF + HS;
        cur.vs    = v >= VA + VF && v < VA + VF + VS;
        cur.valid = vi;
        cur.rgb   = ci;
        if (ri) begin
            cur.req = 0; cur.hs = 0; cur.vs = 0;
            p1.req  = 0; p1.hs  = 0; p1.vs  = 0;
        end
        m_uf = ri ? 1'b0 : (p1.req && !vi) ? 1'b1 : ki ? 1'b0 : m_uf;
        p2 = p1;
        p1 = cur;
        if (ri) begin
            m_busy = 0; m_pos = 0;
        end else if (!m_busy) begin
            m_busy = ei; m_pos = 0;
        end else if (!m_enp && !ei && m_pos == FRAME - 1) begin
            m_busy = 0; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        m_enp = ei;
        if (ri) armed = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          r, e, v, k;
        logic [23:0] c;
        bit          busy, req, fs, de, uf;
        int          x;
        logic [23:0] col;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int cnt_req, cnt_hs, cnt_vs, n;
        bit e_r;
        rst = 1; en = 0; valid = 0; rgb = '0; clr = 0;
        p1 = '{0, 0, 0, 0, 0, 24'h0};
        p2 = p1;
        // Expected values are the outputs seen one clock after each row's inputs.
        tbl[0] = '{1, 0, 0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 24'h000000};
        tbl[1] = '{0, 1, 0, 0, 24'h000000, 1, 1, 1, 0, 0, 0, 24'h000000};
        tbl[2] = '{0, 1, 1, 0, 24'hAAAAAA, 1, 1, 0, 0, 0, 1, 24'h000000};
        tbl[3] = '{0, 1, 1, 0, 24'h123456, 1, 1, 0, 1, 0, 2, 24'h123456};
        tbl[4] = '{0, 1, 0, 0, 24'hDEAD00, 1, 1, 0, 1, 1, 3, fill(1)};
        tbl[5] = '{0, 1, 1, 1, 24'h0A0B0C, 1, 1, 0, 1, 0, 4, 24'h0A0B0C};
        tbl[6] = '{0, 1, 1, 0, 24'hFFFFFF, 1, 1, 0, 1, 0, 5, 24'hFFFFFF};
        tbl[7] = '{0, 1, 0, 1, 24'h777777, 1, 1, 0, 1, 1, 6, fill(4)};
        tbl[8] = '{1, 1, 1, 0, 24'h555555, 0, 0, 0, 0, 0, 0, 24'h000000};
        tbl[9] = '{0, 0, 1, 0, 24'h555555, 0, 0, 0, 0, 0, 0, 24'h000000};
        @(negedge clk);
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].c, tbl[i].k);
            chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
            chk($sformatf("row%0d pix_req", i), pix_req, tbl[i].req);
            chk($sformatf("row%0d frame_start", i), frame_start, tbl[i].fs);
            chk($sformatf("row%0d pix_x", i), pix_x, tbl[i].x);
            chk($sformatf("row%0d data_en", i), data_en, tbl[i].de);
            chk($sformatf("row%0d rgb", i), {r, g, b}, tbl[i].col);
            chk($sformatf("row%0d underflow", i), underflow, tbl[i].uf);
            chk($sformatf("row%0d hsync", i), hsync, !POL);
        end

        // One full frame with data always valid.
        cycle(1, 0, 0, 24'h0, 0);
        cycle(0, 1, 0, 24'h0, 0);
        cnt_req = 0; cnt_hs = 0; cnt_vs = 0;
        for (int i = 0; i < FRAME; i++) begin
            cnt_req += int'(pix_req);
            cnt_hs  += int'(hsync == POL);
            cnt_vs  += int'(vsync == POL);
            cycle(0, 1, 1, 24'($urandom), 0);
        end
        chk("frame requests", cnt_req, HA * VA);
        chk("frame hsync cycles", cnt_hs, HS * VT);
        chk("frame vsync cycles", cnt_vs, VS * HT);
        chk("frame underflow", underflow, 0);

        // Drop enable mid-frame: busy until the frame wraps, then idle.
        for (int i = 0; i < 3 * HT + 5; i++) cycle(0, 1, 1, 24'($urandom), 0);
        n = 0;
        while (busy && n < 2 * FRAME) begin
            n++;
            cycle(0, 0, 1, 24'($urandom), 0);
        end
        chk("drain length", n, FRAME - (3 * HT + 5));
        for (int i = 0; i < 20; i++) cycle(0, 0, 1'($urandom), 24'($urandom), 0);

        // Re-enable during drain: the frame continues uninterrupted.
        cycle(0, 1, 0, 24'h0, 0);
        for (int i = 0; i < 3 * HT + 5; i++) cycle(0, 1, 1, 24'($urandom), 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 24'($urandom), 0);
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            n++;
            cycle(0, 1, 1, 24'($urandom), 0);
        end
        chk("re-enable next frame", n, FRAME - (3 * HT + 15));

        // Random traffic, including valid pulses in blanking, underflows, clears and resets.
        e_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) e_r = !e_r;
            cycle($urandom_range(0, 499) == 0, e_r, $urandom_range(0, 9) != 0,
                  24'($urandom), $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL provide parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, SYNC_POL 0 (sync asserted level; 0 = active-low).
REQ-002 SHALL provide ports:
- clock  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- i_enable  in  1  run request
- o_pix_req  out  1  pixel fetch request for (o_pix_x, o_pix_y)
- o_pix_x  out  10  requested pixel column
- o_pix_y  out  10  requested pixel row
- i_pix_valid  in  1  pixel data valid, one cycle after o_pix_req
- i_pix_rgb  in  24  pixel data {r,g,b}
- o_frame_start  out  1  one-cycle pulse at counter position (0,0)
- o_data_en, o_hsync, o_vsync  out  1 each  video timing to TMDS encoders
- o_r, o_g, o_b  out  8 each  pixel colour
- o_busy  out  1  high in RUN or DRAIN
- o_underflow  out  1  sticky missing-pixel flag
- i_underflow_clr  in  1  clears o_underflow

Function
REQ-003 SHALL keep h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 (H_TOTAL=800, V_TOTAL=525 at defaults); h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1.
REQ-004 SHALL implement FSM IDLE, RUN, DRAIN; IDLE: counters held at 0; IDLE->RUN when i_enable=1, first counted position (0,0) on the next cycle.
REQ-005 SHALL go RUN->DRAIN when i_enable=0; DRAIN->IDLE on the cycle the counters wrap from (H_TOTAL-1,V_TOTAL-1); DRAIN->RUN if i_enable returns to 1 before the wrap, with no frame interruption.
REQ-006 SHALL define active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); o_pix_req = active in RUN/DRAIN, combinational from counter registers; o_pix_x=h_cnt, o_pix_y=v_cnt.
REQ-007 SHALL assert o_frame_start for exactly one cycle when counters are (0,0) in RUN/DRAIN.
REQ-008 SHALL assert hsync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; output level = SYNC_POL when asserted, ~SYNC_POL otherwise.
REQ-009 SHALL register all video outputs with fixed latency 2 cycles from counter stage: o_data_en/o_hsync/o_vsync/o_r/o_g/o_b reflect counter position at cycle t at cycle t+2.
REQ-010 SHALL latch i_pix_rgb at t+1 when a request was made at t and i_pix_valid=1; colour driven at t+2.
REQ-011 SHALL treat request at t with i_pix_valid=0 at t+1 as underflow: set o_underflow at t+2, output substitute colour (see Configuration) for that pixel.
REQ-012 SHALL ignore i_pix_valid when no request was made the previous cycle.
REQ-013 SHALL drive o_r/o_g/o_b = 0 whenever delayed data_en is 0.
REQ-014 SHALL clear o_underflow on i_underflow_clr; simultaneous set and clear: set wins.
REQ-015 SHALL, on entry to IDLE, hold o_data_en=0, syncs at ~SYNC_POL, colour 0 after pipeline flush (2 cycles).

Reset
REQ-016 SHALL on reset (any state, mid-frame included) go to IDLE, counters 0, pipeline cleared, o_underflow=0, o_pix_req=0, o_frame_start=0, o_busy=0, o_data_en=0, o_hsync=o_vsync=~SYNC_POL, colour 0, all on the next clock edge.

Configuration
REQ-017 SHALL with VGA_TEST_PATTERN_EN defined substitute 8 vertical colour bars on underflow (bar = x/(H_ACTIVE/8); bar index bits {2,1,0} select r,g,b = 8'hFF or 0; bar 0 black, bar 7 white).
REQ-018 SHALL without VGA_TEST_PATTERN_EN substitute black (0,0,0) on underflow; no bar logic present.

Verification
REQ-019 Reset, i_enable=1 one cycle later -> o_frame_start pulse at cycle 2 after enable, o_pix_req=1 with x=0,y=0, o_data_en=1 two cycles after.
REQ-020 Full frame, valid always 1 -> exactly 307200 requests, hsync low 96 cycles per 800-cycle line, vsync low 2 lines per 525, o_underflow=0.
REQ-021 Withhold i_pix_valid for pixel (100,20) -> o_underflow=1 at t+2; colour 0 (or bar 1 = 0,0,FF with macro); i_underflow_clr -> 0.
REQ-022 Drop i_enable at (300,200) -> o_busy stays 1 until wrap at (799,524), then IDLE, no further requests; re-enable before wrap -> continuous frames.
REQ-023 Assert reset at (400,100) -> next cycle all outputs at reset values, counters 0, no request.
REQ-024 i_pix_valid pulse during blanking (h=700) -> ignored, colour 0, no underflow.
